// File: rtl/ultrasonic_scan_ctrl.sv
`timescale 1ns/1ps
// Round-robin ultrasonic ranging scheduler: one trigger/echo/convert datapath
// time-shared across N_SENSORS sensors, producing one tagged result per slot.
module ultrasonic_scan_ctrl #(
   parameter int unsigned N_SENSORS     = 4,
   parameter int unsigned SEL_W         = 2,
   parameter int unsigned TRIG_CYCLES   = 1000,
   parameter int unsigned CYCLES_PER_CM = 5800,
   parameter int unsigned MAX_CM        = 400,
   parameter int unsigned ECHO_TIMEOUT  = 1000000,
   parameter int unsigned SLOT_CYCLES   = 6000000
) (
   input  logic                 clk_100MHz,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic [N_SENSORS-1:0] echo_in,
   output logic [N_SENSORS-1:0] trig_out,
   output logic                 result_valid,
   output logic [SEL_W-1:0]     result_sel,
   output logic [10:0]          result_cm,
   output logic                 result_timeout,
   output logic                 busy,
   output logic [SEL_W-1:0]     cur_sel
);

   localparam int unsigned CM_W   = 11;
   localparam int unsigned SLOT_W = $clog2(SLOT_CYCLES);
   localparam int unsigned PRE_W  = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT,
      S_MEAS,
      S_HOLD
   } state_t;

   state_t                 state;
   logic [N_SENSORS-1:0]   echo_meta;
   logic [N_SENSORS-1:0]   echo_sync;
   logic                   echo_prev;
   logic                   echo_s;
   logic                   echo_rise;
   logic [SLOT_W-1:0]      slot_cnt;
   logic [PRE_W-1:0]       presc;
   logic [CM_W-1:0]        cm;
   logic [SEL_W-1:0]       sel_next;

   assign echo_s    = echo_sync[cur_sel];
   assign echo_rise = echo_s & ~echo_prev;
   assign sel_next  = (cur_sel == SEL_W'(N_SENSORS - 1)) ? '0 : cur_sel + SEL_W'(1);

   // Two-flop synchronizer on every echo line; echo_prev tracks the selected line for edge detect
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         echo_meta <= '0;
         echo_sync <= '0;
         echo_prev <= 1'b0;
      end else begin
         echo_meta <= echo_in;
         echo_sync <= echo_meta;
         echo_prev <= echo_s;
      end
   end

   // Slot scheduler; slot_cnt runs from the first trigger cycle to SLOT_CYCLES-1
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         trig_out       <= '0;
         result_valid   <= 1'b0;
         result_sel     <= '0;
         result_cm      <= '0;
         result_timeout <= 1'b0;
         busy           <= 1'b0;
         cur_sel        <= '0;
         slot_cnt       <= '0;
         presc          <= '0;
         cm             <= '0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enable) begin
                  state    <= S_TRIG;
                  busy     <= 1'b1;
                  slot_cnt <= '0;
                  trig_out <= N_SENSORS'(1) << cur_sel;
               end
            end

            S_TRIG: begin
               slot_cnt <= slot_cnt + SLOT_W'(1);
               if (slot_cnt == SLOT_W'(TRIG_CYCLES - 1)) begin
                  trig_out <= '0;
                  state    <= S_WAIT;
               end
            end

            S_WAIT: begin
               slot_cnt <= slot_cnt + SLOT_W'(1);
               // The edge cycle is itself the first counted high cycle
               if (echo_rise) begin
                  state <= S_MEAS;
                  presc <= PRE_W'(1);
                  cm    <= '0;
               end else if (slot_cnt == SLOT_W'(TRIG_CYCLES + ECHO_TIMEOUT - 1)) begin
                  result_valid   <= 1'b1;
                  result_sel     <= cur_sel;
                  result_cm      <= '0;
                  result_timeout <= 1'b1;
                  state          <= S_HOLD;
               end
            end

            S_MEAS: begin
               slot_cnt <= slot_cnt + SLOT_W'(1);
               if (!echo_s) begin
                  result_valid   <= 1'b1;
                  result_sel     <= cur_sel;
                  result_cm      <= cm;
                  result_timeout <= 1'b0;
                  state          <= S_HOLD;
               end else if (presc == PRE_W'(CYCLES_PER_CM - 1)) begin
                  presc <= '0;
                  if (cm == CM_W'(MAX_CM - 1)) begin
                     result_valid   <= 1'b1;
                     result_sel     <= cur_sel;
                     result_cm      <= CM_W'(MAX_CM);
                     result_timeout <= 1'b1;
                     state          <= S_HOLD;
                  end else begin
                     cm <= cm + CM_W'(1);
                  end
               end else begin
                  presc <= presc + PRE_W'(1);
               end
            end

            S_HOLD: begin
               if (slot_cnt == SLOT_W'(SLOT_CYCLES - 1)) begin
                  cur_sel  <= sel_next;
                  slot_cnt <= '0;
                  if (enable) begin
                     state    <= S_TRIG;
                     trig_out <= N_SENSORS'(1) << sel_next;
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  slot_cnt <= slot_cnt + SLOT_W'(1);
               end
            end

            default: begin
               state    <= S_IDLE;
               busy     <= 1'b0;
               trig_out <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ultrasonic_scan_ctrl.sv
`timescale 1ns/1ps
// Directed bench for ultrasonic_scan_ctrl: expected results are queued as echoes
// are driven and checked when result_valid fires.
module tb_ultrasonic_scan_ctrl;

   localparam int N_SENSORS = 3;
   localparam int SEL_W     = 2;
   localparam int TRIG      = 10;
   localparam int SLOT      = 1000;

   logic                 clk_100MHz = 1'b0;
   logic                 reset_n;
   logic                 enable;
   logic [N_SENSORS-1:0] echo_in;
   logic [N_SENSORS-1:0] trig_out;
   logic                 result_valid;
   logic [SEL_W-1:0]     result_sel;
   logic [10:0]          result_cm;
   logic                 result_timeout;
   logic                 busy;
   logic [SEL_W-1:0]     cur_sel;

   ultrasonic_scan_ctrl #(
      .N_SENSORS     (N_SENSORS),
      .SEL_W         (SEL_W),
      .TRIG_CYCLES   (TRIG),
      .CYCLES_PER_CM (10),
      .MAX_CM        (50),
      .ECHO_TIMEOUT  (200),
      .SLOT_CYCLES   (SLOT)
   ) dut (
      .clk_100MHz     (clk_100MHz),
      .reset_n        (reset_n),
      .enable         (enable),
      .echo_in        (echo_in),
      .trig_out       (trig_out),
      .result_valid   (result_valid),
      .result_sel     (result_sel),
      .result_cm      (result_cm),
      .result_timeout (result_timeout),
      .busy           (busy),
      .cur_sel        (cur_sel)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   typedef struct {
      int sel;
      int cm;
      int to;
      int at;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   cyc      = 0;
   int   n_pass   = 0;
   int   n_total  = 0;
   int   n_pushed = 0;
   int   n_seen   = 0;

   always @(posedge clk_100MHz) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_100MHz);
   endtask

   task automatic push(input int sel, input int cm, input int to, input int at);
      exp_t x;
      x.sel = sel; x.cm = cm; x.to = to; x.at = at;
      q.push_back(x);
      n_pushed++;
   endtask

   task automatic wait_rise(input int idx, input int budget, output int t);
      int n = 0;
      while (trig_out[idx] !== 1'b1 && n < budget) begin
         @(negedge clk_100MHz);
         n++;
      end
      check($sformatf("trig%0d_rise_seen", idx), 32'(trig_out[idx]), 32'd1);
      t = cyc;
   endtask

   task automatic trig_width(input int idx);
      int w = 0;
      while (trig_out[idx] === 1'b1 && w < 100) begin
         w++;
         @(negedge clk_100MHz);
      end
      check($sformatf("trig%0d_width", idx), 32'(w), 32'(TRIG));
   endtask

   // Scoreboard: compare each emitted result with the oldest queued expectation
   always @(negedge clk_100MHz) begin
      if (reset_n === 1'b1 && result_valid === 1'b1) begin
         n_seen++;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("res_sel", 32'(result_sel), 32'(e.sel));
            check("res_cm", 32'(result_cm), 32'(e.cm));
            check("res_timeout", 32'(result_timeout), 32'(e.to));
            check("res_cycle", 32'(cyc), 32'(e.at));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t_prev, t_now, n;
      reset_n = 1'b0;
      enable  = 1'b0;
      echo_in = '0;
      tick(3);
      check("rst_trig", 32'(trig_out), 32'd0);
      check("rst_valid", 32'(result_valid), 32'd0);
      check("rst_sel", 32'(result_sel), 32'd0);
      check("rst_cm", 32'(result_cm), 32'd0);
      check("rst_timeout", 32'(result_timeout), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cur_sel", 32'(cur_sel), 32'd0);
      reset_n = 1'b1;
      tick(3);
      check("idle_busy", 32'(busy), 32'd0);

      // 1: sensor 0, echo 30 clk after trigger, 125 clk high -> 12 cm
      enable = 1'b1;
      wait_rise(0, 20, t_prev);
      check("t1_busy", 32'(busy), 32'd1);
      trig_width(0);
      tick(30);
      echo_in[0] = 1'b1;
      tick(125);
      echo_in[0] = 1'b0;
      push(0, 12, 0, cyc + 3);

      // 2: sensor 1 silent -> timeout 200 clk after trigger falls
      wait_rise(1, 2000, t_now);
      check("t2_period", 32'(t_now - t_prev), 32'(SLOT));
      t_prev = t_now;
      trig_width(1);
      push(1, 0, 1, cyc + 200);

      // 3: sensor 2 held high 800 clk -> saturates at 50 cm
      wait_rise(2, 2000, t_now);
      check("t3_period", 32'(t_now - t_prev), 32'(SLOT));
      t_prev = t_now;
      trig_width(2);
      tick(5);
      echo_in[2] = 1'b1;
      push(2, 50, 1, cyc + 502);
      tick(800);
      echo_in[2] = 1'b0;

      // 4: sensor 0 echo already high at trigger end; only the re-rise is measured
      wait_rise(0, 2000, t_now);
      check("t4_period", 32'(t_now - t_prev), 32'(SLOT));
      check("t4_wrap_sel", 32'(cur_sel), 32'd0);
      t_prev = t_now;
      echo_in[0] = 1'b1;
      trig_width(0);
      tick(20);
      echo_in[0] = 1'b0;
      tick(20);
      echo_in[0] = 1'b1;
      tick(40);
      echo_in[0] = 1'b0;
      push(0, 4, 0, cyc + 3);

      // 5: enable dropped mid-measure; result still emitted, then idle
      wait_rise(1, 2000, t_now);
      check("t5_period", 32'(t_now - t_prev), 32'(SLOT));
      t_prev = t_now;
      trig_width(1);
      tick(5);
      echo_in[1] = 1'b1;
      tick(30);
      enable = 1'b0;
      tick(47);
      echo_in[1] = 1'b0;
      push(1, 7, 0, cyc + 3);
      n = 0;
      while (cyc < t_prev + SLOT - 1 && n < 2000) begin
         @(negedge clk_100MHz);
         n++;
      end
      check("t5_busy_last", 32'(busy), 32'd1);
      tick(1);
      check("t5_busy_fall", 32'(busy), 32'd0);
      check("t5_sel_adv", 32'(cur_sel), 32'd2);
      n = 0;
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk_100MHz);
         if (trig_out !== '0) n++;
      end
      check("t5_no_trig", 32'(n), 32'd0);
      check("t5_cm_hold", 32'(result_cm), 32'd7);
      check("t5_busy_idle", 32'(busy), 32'd0);

      // 6: reset mid-trigger clears everything at once, then a full pulse on sensor 0
      enable = 1'b1;
      wait_rise(2, 20, t_now);
      tick(4);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_trig", 32'(trig_out), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_cur_sel", 32'(cur_sel), 32'd0);
      check("t6_res_sel", 32'(result_sel), 32'd0);
      check("t6_res_cm", 32'(result_cm), 32'd0);
      check("t6_valid", 32'(result_valid), 32'd0);
      tick(2);
      reset_n = 1'b1;
      wait_rise(0, 20, t_now);
      trig_width(0);
      push(0, 0, 1, cyc + 200);

      n = 0;
      while (q.size() > 0 && n < 400) begin
         @(negedge clk_100MHz);
         n++;
      end
      tick(2);
      check("results_count", 32'(n_seen), 32'(n_pushed));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ultrasonic_scan_ctrl.md
Name: ultrasonic_scan_ctrl

Overview:
Round-robin scheduler that shares one ultrasonic ranging datapath across N_SENSORS HC-SR04-style sensors. Per time slot it:
- fires one trigger pulse on the selected sensor,
- waits for that sensor's echo,
- converts the echo width to centimetres with a prescaled counter (no divider),
- reports one tagged result.

It sits between the sensor pins and the display/speaker logic, and supersedes free-running single-sensor ranging.

Parameters:
N_SENSORS, 4, number of sensors scanned (2..8)
SEL_W, 2, width of sensor index (>= clog2(N_SENSORS))
TRIG_CYCLES, 1000, trigger high time in clocks (10 us)
CYCLES_PER_CM, 5800, clocks of echo per centimetre (58 us/cm)
MAX_CM, 400, saturation distance; 11-bit
ECHO_TIMEOUT, 1000000, clocks after trigger end allowed for echo rising edge
SLOT_CYCLES, 6000000, clocks per sensor slot, trigger start to next trigger start (60 ms); must exceed TRIG_CYCLES+ECHO_TIMEOUT+MAX_CM*CYCLES_PER_CM+8

Ports:
clk_100MHz  input  1  system clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  level; scanning runs while high
echo_in  input  N_SENSORS  raw echo lines, asynchronous
trig_out  output  N_SENSORS  registered trigger lines, at most one high
result_valid  output  1  one-cycle pulse, result fields valid
result_sel  output  SEL_W  sensor index of result
result_cm  output  11  distance in cm, floor, saturated at MAX_CM
result_timeout  output  1  no echo, or echo longer than MAX_CM
busy  output  1  high in any state except IDLE
cur_sel  output  SEL_W  sensor currently scheduled

Behaviour:
- Reset (async assert, sync release):
  - trig_out=0, result_valid=0, result_sel=0, result_cm=0, result_timeout=0, busy=0, cur_sel=0.
  - All counters cleared; state IDLE.
  - Reset mid-slot drops trig_out immediately and discards the measurement.
- echo_in: each bit passes through a 2-flop synchronizer. All echo logic uses the synchronized copy (echo_s) of bit cur_sel only; other bits are ignored.
- State machine, all outputs registered:
  - IDLE: if enable=1, go to TRIG next cycle.
  - TRIG:
    - trig_out[cur_sel]=1 for exactly TRIG_CYCLES cycles.
    - Slot counter starts at 0 on the first TRIG cycle.
    - Then go to WAIT_ECHO.
  - WAIT_ECHO:
    - Waits for a rising edge of echo_s (previous 0, current 1). An echo already high on entry is not accepted until it goes low then high.
    - On edge, go to MEASURE with prescaler=0 and cm=0.
    - If ECHO_TIMEOUT cycles elapse without an edge: emit result with cm=0, timeout=1, then go to HOLD.
  - MEASURE:
    - Prescaler counts every cycle echo_s=1.
    - At CYCLES_PER_CM-1 the prescaler wraps to 0 and cm increments.
    - When echo_s is seen 0: emit result with cm=floor(H/CYCLES_PER_CM), where H = synchronized high cycles. Then go to HOLD.
    - If cm reaches MAX_CM while echo is high: emit cm=MAX_CM, timeout=1, then go to HOLD. The rest of the echo is ignored.
  - HOLD:
    - Waits until slot counter = SLOT_CYCLES-1.
    - Then cur_sel advances: +1, wrapping N_SENSORS-1 to 0.
    - If enable=1, next cycle is TRIG; else IDLE.
- Emit: result_valid=1 for one cycle, with result_sel=cur_sel. result_cm and result_timeout hold their value until the next emit.
- Latency: echo_in fall to result_valid is 3 cycles (2 synchronizer + 1 register).
- Trigger-to-trigger period across consecutive sensors is exactly SLOT_CYCLES.
- enable: deassertion mid-slot completes the current slot, including its result, then goes IDLE. cur_sel keeps its advanced value and is not reset by enable.
- Echo edge and timeout on the same cycle: the edge wins.
- Saturation and fall on the same cycle: report MAX_CM with timeout=1.

Test Plan:
Sim parameters: N_SENSORS=3, TRIG_CYCLES=10, CYCLES_PER_CM=10, MAX_CM=50, ECHO_TIMEOUT=200, SLOT_CYCLES=1000.
1. enable=1; sensor 0 echo rises 30 clk after trig falls, high 125 clk -> trig_out[0] high exactly 10 clk; result_valid once with sel=0, cm=12, timeout=0, 3 clk after echo falls.
2. No echo on sensor 1 -> result sel=1, cm=0, timeout=1, 200 clk after trig_out[1] falls; trig_out[2] rises exactly 1000 clk after trig_out[1] rose.
3. Sensor 2 echo held high 800 clk -> result cm=50, timeout=1 at saturation; next slot wraps to cur_sel=0.
4. Sensor 0 echo already high at trigger end, falls, re-rises, high 40 clk -> only the second pulse is measured; cm=4.
5. enable dropped mid-MEASURE -> result still emitted; busy falls at slot end; no further trig_out.
6. reset_n asserted mid-TRIG -> trig_out and all outputs 0 asynchronously; after release with enable=1, trig_out[0] restarts from a full 10-clk pulse.
